de1_soc_switch_reader: RTL

DE1_SOC_SWITCH_READER -- requirements
Module: de1_soc_switch_reader

---
 rtl/de1_soc_switch_reader.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/de1_soc_switch_reader.sv
// Avalon-MM master that services a DE1-SoC switch PIO: programs its IRQ mask,
// reads the switch value on interrupt or poll timeout, and streams changed values out.
module de1_soc_switch_reader #(
    parameter int              WIDTH       = 10,
    parameter logic [WIDTH-1:0] MASK_INIT  = '1,
    parameter int              POLL_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [1:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
    output logic [31:0]      avm_writedata,
    input  logic [31:0]      avm_readdata,
    input  logic             avm_irq,
    input  logic             mask_wr,
    input  logic [WIDTH-1:0] mask_data,
    output logic [WIDTH-1:0] sample_data,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic [2:0]       o_dbg_state
);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_WRMASK = 3'd2,
        S_RDADDR = 3'd3,
        S_RDDATA = 3'd4,
        S_OUT    = 3'd5
    } state_t;

    localparam int             CW        = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [CW-1:0]  POLL_LAST = (POLL_CYCLES > 0) ? CW'(POLL_CYCLES - 1) : '0;

    state_t           r_state;
    logic [1:0]       r_address;
    logic             r_chipselect;
    logic             r_write_n;
    logic [31:0]      r_writedata;
    logic [WIDTH-1:0] r_sample_data;
    logic             r_sample_valid;
    logic             r_delivered;
    logic             r_mask_pend;
    logic [WIDTH-1:0] r_mask_val;
    logic [CW-1:0]    r_poll_cnt;

    logic             w_poll_hit;
    logic             w_rd_changed;
    logic             w_unused_rd;

    // Polling is disabled entirely when POLL_CYCLES is zero.
    assign w_poll_hit   = (POLL_CYCLES > 0) && (r_poll_cnt == POLL_LAST);
    assign w_rd_changed = (avm_readdata[WIDTH-1:0] != r_sample_data) || !r_delivered;
    assign w_unused_rd  = ^avm_readdata;

    // Output handshake: a value moves when sample_valid and sample_ready are both
    // high on a rising clk edge; sample_valid/sample_data hold steady until then.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_INIT;
            r_address      <= 2'd0;
            r_chipselect   <= 1'b0;
            r_write_n      <= 1'b1;
            r_writedata    <= 32'd0;
            r_sample_data  <= '0;
            r_sample_valid <= 1'b0;
            r_delivered    <= 1'b0;
            r_mask_pend    <= 1'b0;
            r_mask_val     <= '0;
            r_poll_cnt     <= '0;
        end else begin
            r_address    <= 2'd0;
            r_chipselect <= 1'b0;
            r_write_n    <= 1'b1;
            r_writedata  <= 32'd0;
            r_poll_cnt   <= '0;

            if (mask_wr) begin
                r_mask_pend <= 1'b1;
                r_mask_val  <= mask_data;
            end

            case (r_state)
                S_INIT: begin
                    // Bus registers load on the first edge, so INIT spans the launch
                    // edge plus the strobe cycle itself.
                    if (!r_chipselect) begin
                        r_address    <= 2'd2;
                        r_chipselect <= 1'b1;
                        r_write_n    <= 1'b0;
                        r_writedata  <= 32'(MASK_INIT);
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (r_mask_pend) begin
                        r_address    <= 2'd2;
                        r_chipselect <= 1'b1;
                        r_write_n    <= 1'b0;
                        r_writedata  <= 32'(r_mask_val);
                        r_mask_pend  <= mask_wr;
                        r_state      <= S_WRMASK;
                    end else if (avm_irq || w_poll_hit) begin
                        r_address    <= 2'd0;
                        r_chipselect <= 1'b1;
                        r_write_n    <= 1'b1;
                        r_state      <= S_RDADDR;
                    end else begin
                        r_poll_cnt <= r_poll_cnt + 1'b1;
                    end
                end
                S_WRMASK: r_state <= S_IDLE;
                S_RDADDR: r_state <= S_RDDATA;
                S_RDDATA: begin
                    if (w_rd_changed) begin
                        r_sample_data  <= avm_readdata[WIDTH-1:0];
                        r_sample_valid <= 1'b1;
                        r_delivered    <= 1'b1;
                        r_state        <= S_OUT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_OUT: begin
                    if (sample_ready) begin
                        r_sample_valid <= 1'b0;
                        r_state        <= S_IDLE;
                    end
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

    assign avm_address    = r_address;
    assign avm_chipselect = r_chipselect;
    assign avm_write_n    = r_write_n;
    assign avm_writedata  = r_writedata;
    assign sample_data    = r_sample_data;
    assign sample_valid   = r_sample_valid;
    assign o_dbg_state    = r_state;

endmodule
